// File: rtl/missile_pool_pkg.sv
// Shared constants and types for the invader missile pool.
package missile_pool_pkg;

    // Screen and sprite geometry shared with the rest of the video pipeline.
    localparam int SCREEN_H        = 480;
    localparam int SPRITE_W        = 24;
    localparam int SPRITE_H        = 24;
    localparam int MISSILE_H       = 16;
    localparam int INV_COL_PITCH   = 36;
    localparam int MISSILE_STEP    = 4;
    localparam int LAUNCH_COOLDOWN = 8;

    typedef enum logic {
        SLOT_IDLE   = 1'b0,
        SLOT_FLYING = 1'b1
    } slot_state_t;

    // Index width that stays at least one bit wide for single-entry tables.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/missile_pool_col_arbiter.sv
// Round-robin column picker: first set request bit at or after the pointer.
module col_arbiter
    import missile_pool_pkg::*;
#(
    parameter int COLS  = 11,
    parameter int PTR_W = clog2_min1(COLS)
) (
    input  logic [COLS-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_found,
    output logic [PTR_W-1:0] o_idx,
    output logic [PTR_W-1:0] o_next_ptr
);

    logic [PTR_W:0]   w_cand;
    logic [PTR_W-1:0] w_cand_idx;

    // Walk the columns starting at the pointer, wrapping at COLS.
    always_comb begin
        o_found    = 1'b0;
        o_idx      = '0;
        w_cand     = '0;
        w_cand_idx = '0;
        for (int k = 0; k < COLS; k++) begin
            w_cand = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_cand >= (PTR_W+1)'(COLS)) begin
                w_cand = w_cand - (PTR_W+1)'(COLS);
            end
            w_cand_idx = w_cand[PTR_W-1:0];
            if (!o_found && i_req[w_cand_idx]) begin
                o_found = 1'b1;
                o_idx   = w_cand_idx;
            end
        end
    end

    // Pointer advances to the column after the one just served.
    always_comb begin
        if (o_idx == PTR_W'(COLS - 1)) begin
            o_next_ptr = '0;
        end else begin
            o_next_ptr = o_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/missile_pool.sv
// Pool of invader missile slots: launches from live columns, advances per frame,
// retires at the bottom of the screen or on a collision.
//
// Per-slot states:
//   state       | meaning
//   SLOT_IDLE   | slot free, outputs forced to zero, may be launched
//   SLOT_FLYING | missile in flight, y advances by STEP each frame
module missile_pool
    import missile_pool_pkg::*;
#(
    parameter int NUM_MISSILES    = 3,
    parameter int COORD_W         = 10,
    parameter int COLS            = 11,
    parameter int COL_PITCH       = INV_COL_PITCH,
    parameter int X_OFFSET        = SPRITE_W / 2,
    parameter int Y_OFFSET        = SPRITE_H,
    parameter int STEP            = MISSILE_STEP,
    parameter int Y_LIMIT         = SCREEN_H - MISSILE_H,
    parameter int COOLDOWN_FRAMES = LAUNCH_COOLDOWN
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            frame,
    input  logic                            enable,
    input  logic                            clear,
    input  logic [COORD_W-1:0]              formation_x,
    input  logic [COORD_W-1:0]              formation_y,
    input  logic [COLS-1:0]                 col_alive,
    input  logic [NUM_MISSILES-1:0]         hit,
    output logic [NUM_MISSILES*COORD_W-1:0] m_x,
    output logic [NUM_MISSILES*COORD_W-1:0] m_y,
    output logic [NUM_MISSILES-1:0]         m_active,
    output logic                            launch
);

    localparam int PTR_W  = clog2_min1(COLS);
    localparam int SLOT_W = clog2_min1(NUM_MISSILES);
    localparam int CD_W   = clog2_min1(COOLDOWN_FRAMES + 1);

    slot_state_t        r_state     [NUM_MISSILES];
    logic [COORD_W-1:0] r_x         [NUM_MISSILES];
    logic [COORD_W-1:0] r_y         [NUM_MISSILES];
    logic [PTR_W-1:0]   r_col_ptr;
    logic [CD_W-1:0]    r_cooldown;
    logic               r_launch;

    slot_state_t        w_state_nxt [NUM_MISSILES];
    logic [COORD_W-1:0] w_x_nxt     [NUM_MISSILES];
    logic [COORD_W-1:0] w_y_nxt     [NUM_MISSILES];
    logic [COORD_W:0]   w_y_step    [NUM_MISSILES];
    logic [PTR_W-1:0]   w_col_ptr_nxt;
    logic [CD_W-1:0]    w_cooldown_nxt;

    logic               w_col_found;
    logic [PTR_W-1:0]   w_col_idx;
    logic [PTR_W-1:0]   w_col_next;
    logic               w_slot_found;
    logic [SLOT_W-1:0]  w_slot_sel;
    logic               w_launch;
    logic [COORD_W-1:0] w_launch_x;
    logic [COORD_W-1:0] w_launch_y;

    col_arbiter #(
        .COLS  (COLS),
        .PTR_W (PTR_W)
    ) u_col_arbiter (
        .i_req      (col_alive),
        .i_ptr      (r_col_ptr),
        .o_found    (w_col_found),
        .o_idx      (w_col_idx),
        .o_next_ptr (w_col_next)
    );

    // Lowest-index slot that was idle at the start of this cycle.
    always_comb begin
        w_slot_found = 1'b0;
        w_slot_sel   = '0;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            if (!w_slot_found && (r_state[i] == SLOT_IDLE)) begin
                w_slot_found = 1'b1;
                w_slot_sel   = SLOT_W'(i);
            end
        end
    end

    // Launch decision, per-slot next state, column pointer and cooldown.
    always_comb begin
        w_launch   = frame && enable && !clear && (r_cooldown == '0)
                     && w_slot_found && w_col_found;
        w_launch_x = formation_x + COORD_W'(w_col_idx) * COORD_W'(COL_PITCH)
                     + COORD_W'(X_OFFSET);
        w_launch_y = formation_y + COORD_W'(Y_OFFSET);

        w_col_ptr_nxt  = r_col_ptr;
        w_cooldown_nxt = r_cooldown;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            w_state_nxt[i] = r_state[i];
            w_x_nxt[i]     = r_x[i];
            w_y_nxt[i]     = r_y[i];
            // One extra bit so a missile near the bottom cannot wrap to the top.
            w_y_step[i]    = {1'b0, r_y[i]} + (COORD_W+1)'(STEP);
        end

        if (clear) begin
            w_col_ptr_nxt  = '0;
            w_cooldown_nxt = '0;
            for (int i = 0; i < NUM_MISSILES; i++) begin
                w_state_nxt[i] = SLOT_IDLE;
                w_x_nxt[i]     = '0;
                w_y_nxt[i]     = '0;
            end
        end else begin
            for (int i = 0; i < NUM_MISSILES; i++) begin
                if (r_state[i] == SLOT_FLYING) begin
                    if (hit[i]) begin
                        w_state_nxt[i] = SLOT_IDLE;
                        w_x_nxt[i]     = '0;
                        w_y_nxt[i]     = '0;
                    end else if (frame) begin
                        if (w_y_step[i] >= (COORD_W+1)'(Y_LIMIT)) begin
                            w_state_nxt[i] = SLOT_IDLE;
                            w_x_nxt[i]     = '0;
                            w_y_nxt[i]     = '0;
                        end else begin
                            w_y_nxt[i] = w_y_step[i][COORD_W-1:0];
                        end
                    end
                end else if (w_launch && (w_slot_sel == SLOT_W'(i))) begin
                    w_state_nxt[i] = SLOT_FLYING;
                    w_x_nxt[i]     = w_launch_x;
                    w_y_nxt[i]     = w_launch_y;
                end
            end

            if (w_launch) begin
                w_col_ptr_nxt  = w_col_next;
                w_cooldown_nxt = CD_W'(COOLDOWN_FRAMES);
            end else if (frame && (r_cooldown != '0)) begin
                w_cooldown_nxt = r_cooldown - CD_W'(1);
            end
        end
    end

    // State register for all slots, pointer, cooldown and launch pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MISSILES; i++) begin
                r_state[i] <= SLOT_IDLE;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
            end
            r_col_ptr  <= '0;
            r_cooldown <= '0;
            r_launch   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MISSILES; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_x[i]     <= w_x_nxt[i];
                r_y[i]     <= w_y_nxt[i];
            end
            r_col_ptr  <= w_col_ptr_nxt;
            r_cooldown <= w_cooldown_nxt;
            r_launch   <= w_launch;
        end
    end

    // Pack slot registers onto the flat output buses, slot 0 in the LSBs.
    always_comb begin
        m_x      = '0;
        m_y      = '0;
        m_active = '0;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            m_x[i*COORD_W +: COORD_W] = r_x[i];
            m_y[i*COORD_W +: COORD_W] = r_y[i];
            m_active[i]               = (r_state[i] == SLOT_FLYING);
        end
        launch = r_launch;
    end

endmodule

// File: doc/missile_pool.md
MISSILE_POOL -- requirements
Module: missile_pool

Interface
REQ-001 SHALL have parameter NUM_MISSILES, default 3, number of concurrent invader missile slots (1..8).
REQ-002 SHALL have parameter COORD_W, default 10, coordinate width in bits.
REQ-003 SHALL have parameter COLS, default 11, invader columns (1..16).
REQ-004 SHALL have parameter COL_PITCH, default 36, horizontal pixel spacing between columns.
REQ-005 SHALL have parameter X_OFFSET, default 12, launch x offset inside a column (half sprite width).
REQ-006 SHALL have parameter Y_OFFSET, default 24, launch y offset below formation origin.
REQ-007 SHALL have parameter STEP, default 4, pixels advanced per frame.
REQ-008 SHALL have parameter Y_LIMIT, default 464, retire threshold (screen height minus missile height).
REQ-009 SHALL have parameter COOLDOWN_FRAMES, default 8, minimum frames between launches.
REQ-010 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-011 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-012 SHALL have port frame  input  1  one-cycle pulse per video frame.
REQ-013 SHALL have port enable  input  1  launches permitted when 1; flight continues when 0.
REQ-014 SHALL have port clear  input  1  synchronous flush (new wave / player death).
REQ-015 SHALL have ports formation_x, formation_y  input  COORD_W  formation origin.
REQ-016 SHALL have port col_alive  input  COLS  1 = column contains a live invader.
REQ-017 SHALL have port hit  input  NUM_MISSILES  per-slot collision pulse (player or shield).
REQ-018 SHALL have ports m_x, m_y  output  NUM_MISSILES*COORD_W  packed slot positions, slot 0 in LSBs, registered.
REQ-019 SHALL have port m_active  output  NUM_MISSILES  1 = slot in flight, registered.
REQ-020 SHALL have port launch  output  1  one-cycle pulse, registered, on each launch.

Function
REQ-021 Each slot SHALL be a two-state FSM: IDLE, FLYING.
REQ-022 On frame, each FLYING slot SHALL add STEP to y; if the COORD_W+1-bit sum >= Y_LIMIT, slot goes IDLE instead (no wrap).
REQ-023 hit[i] on a FLYING slot SHALL force IDLE next cycle with priority over the frame move; hit on an IDLE slot SHALL be ignored.
REQ-024 Launch SHALL be evaluated only on frame cycles, requiring enable=1, cooldown=0, an IDLE slot and at least one set col_alive bit.
REQ-025 Slot eligibility SHALL use state before the current cycle's retirements/hits; a slot freed this cycle is launchable next frame.
REQ-026 Target column SHALL be the first c at or after col_ptr (wrapping mod COLS) with col_alive[c]=1; col_ptr then becomes (c+1) mod COLS.
REQ-027 Launched slot SHALL be the lowest-index eligible IDLE slot, with x = formation_x + c*COL_PITCH + X_OFFSET, y = formation_y + Y_OFFSET, truncated to COORD_W.
REQ-028 A newly launched missile SHALL NOT advance on its launch frame.
REQ-029 On launch, cooldown SHALL load COOLDOWN_FRAMES; on each non-launch frame it SHALL decrement if nonzero.
REQ-030 With no eligible slot or no live column: no launch, col_ptr and cooldown unchanged except normal decrement.
REQ-031 Outputs SHALL reflect updated state one cycle after frame/hit; IDLE slots SHALL drive m_x=m_y=0.
REQ-032 clear SHALL have priority over all other inputs and produce the reset state next cycle.

Reset
REQ-033 rst_n low SHALL immediately set all slots IDLE, m_x, m_y, m_active, launch to 0, col_ptr to 0, cooldown to 0.

Structure
REQ-034 Screen size, sprite dimensions, column pitch and missile step defaults SHALL come from the shared constants include, not literals.
REQ-035 Column search SHALL be a sub-module col_arbiter (round-robin first-set-bit from pointer, COLS-wide).

Verification
REQ-036 Reset released, formation (100,50), col_alive all 1s, enable=1: frame 1 -> slot0 active x=112 y=74, launch pulse; next frame y=78; next launch on 9th subsequent frame, slot1 x=148.
REQ-037 col_alive=0x021 -> successive launches target columns 0,5,0,5 (x=112,292).
REQ-038 Slot0 at y=460, frame -> slot0 retires (m_active[0]=0), not launchable until following frame.
REQ-039 hit[0] coincident with frame -> slot0 IDLE, outputs 0; all 3 slots FLYING plus ready cooldown -> no launch, col_ptr unchanged.
REQ-040 rst_n low mid-flight -> all outputs 0 without clock edge; clear=1 -> same state after one edge.
